pulse_burst_ctrl: RTL

PULSE_BURST_CTRL -- requirements
Module: pulse_burst_ctrl

---
 rtl/pulse_pkg.sv | 19 +
 rtl/pulse_burst_ctrl_if.sv | 44 ++++
 rtl/pb_downcnt.sv | 30 +++
 rtl/pulse_burst_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding, default widths and timeout margin for pulse_burst_ctrl
package pulse_pkg;

    localparam int DEF_RAM_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    // Extra cycles granted beyond the pulse width before WAIT gives up
    localparam int TIMEOUT_MARGIN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_FIRE,
        ST_WAIT,
        ST_GAP,
        ST_FINISH
    } pb_state_e;

endpackage

// File: rtl/pulse_burst_ctrl_if.sv
// rtl/pulse_burst_ctrl_if.sv - control/config/status bundle of pulse_burst_ctrl; io_error exists only with PULSE_BURST_TIMEOUT_EN
interface pulse_burst_ctrl_if
    import pulse_pkg::*;
#(
    parameter int _RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);

    logic                  io_start;
    logic                  io_abort;
    logic [_RAM_WIDTH-1:0] io_trigDelay;
    logic [_RAM_WIDTH-1:0] io_pulseWidth;
    logic [_RAM_WIDTH-1:0] io_gap;
    logic [CNT_WIDTH-1:0]  io_pulseCount;
    logic                  pulse_valid;
    logic                  io_en;
    logic [_RAM_WIDTH-1:0] io_pulseWidthOut;
    logic                  pwm_dis;
    logic                  io_busy;
    logic                  io_done;
    logic [CNT_WIDTH-1:0]  io_pulsesLeft;
`ifdef PULSE_BURST_TIMEOUT_EN
    logic                  io_error;
`endif

    // Host / pulse-stage side
    modport master (
`ifdef PULSE_BURST_TIMEOUT_EN
        input  io_error,
`endif
        output io_start, io_abort, io_trigDelay, io_pulseWidth, io_gap, io_pulseCount, pulse_valid,
        input  io_en, io_pulseWidthOut, pwm_dis, io_busy, io_done, io_pulsesLeft
    );

    // Controller side
    modport slave (
`ifdef PULSE_BURST_TIMEOUT_EN
        output io_error,
`endif
        input  io_start, io_abort, io_trigDelay, io_pulseWidth, io_gap, io_pulseCount, pulse_valid,
        output io_en, io_pulseWidthOut, pwm_dis, io_busy, io_done, io_pulsesLeft
    );

endinterface

// File: rtl/pb_downcnt.sv
// rtl/pb_downcnt.sv - loadable saturating down-counter with zero flag
module pb_downcnt
    import pulse_pkg::*;
#(
    parameter int WIDTH = DEF_RAM_WIDTH
) (
    input  logic             io_clk,
    input  logic             io_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // Load wins over decrement; decrement stops at zero instead of wrapping
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_burst_ctrl.sv
// rtl/pulse_burst_ctrl.sv - burst sequencer for a downstream pulse stage; optional WAIT timeout under PULSE_BURST_TIMEOUT_EN
module pulse_burst_ctrl
    import pulse_pkg::*;
#(
    parameter int _RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic              io_clk,
    input  logic              io_rst,
    pulse_burst_ctrl_if.slave bus
);

    pb_state_e             state;
    logic                  en_q;
    logic                  pwm_dis_q;
    logic                  busy_q;
    logic                  done_q;
    // left_q holds the latched pulse count, width_q the latched width,
    // and the delay counter itself is the latched trigger delay.
    logic [CNT_WIDTH-1:0]  left_q;
    logic [_RAM_WIDTH-1:0] width_q;
    logic [_RAM_WIDTH-1:0] gap_q;
    // Stand-in end-of-pulse strobe for zero-width pulses, which the pulse stage never reports
    logic [1:0]            zw_sr;

    logic start_acc;
    logic abort_acc;
    logic pulse_end;
    logic tmo_hit;
    logic stop;
    logic dly_zero;
    logic gap_zero;

    function automatic logic [_RAM_WIDTH-1:0] sat_dec(input logic [_RAM_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - _RAM_WIDTH'(1);
    endfunction

    assign start_acc = (state == ST_IDLE) && bus.io_start;
    // FINISH is already winding down, so a late abort there changes nothing
    assign abort_acc = bus.io_abort &&
                       (state inside {ST_DELAY, ST_FIRE, ST_WAIT, ST_GAP});
    assign pulse_end = (state == ST_WAIT) && (bus.pulse_valid || zw_sr[1]);
    assign stop      = abort_acc || tmo_hit;

    // Counters are loaded with value-1 so the FIRE that follows lands exactly value+1 cycles later
    pb_downcnt #(.WIDTH(_RAM_WIDTH)) u_delay (
        .io_clk   (io_clk),
        .io_rst   (io_rst),
        .load     (start_acc),
        .load_val (sat_dec(bus.io_trigDelay)),
        .dec      (state == ST_DELAY),
        .zero     (dly_zero)
    );

    pb_downcnt #(.WIDTH(_RAM_WIDTH)) u_gap (
        .io_clk   (io_clk),
        .io_rst   (io_rst),
        .load     (pulse_end),
        .load_val (sat_dec(gap_q)),
        .dec      (state == ST_GAP),
        .zero     (gap_zero)
    );

`ifdef PULSE_BURST_TIMEOUT_EN
    logic tmo_zero;
    logic err_q;

    function automatic logic [_RAM_WIDTH-1:0] tmo_load_val(input logic [_RAM_WIDTH-1:0] w);
        logic [_RAM_WIDTH-1:0] add;
        add = _RAM_WIDTH'(TIMEOUT_MARGIN - 2);
        return (w > ~add) ? '1 : w + add;
    endfunction

    // Armed in FIRE so it expires width+margin cycles after io_en
    pb_downcnt #(.WIDTH(_RAM_WIDTH)) u_tmo (
        .io_clk   (io_clk),
        .io_rst   (io_rst),
        .load     (state == ST_FIRE),
        .load_val (tmo_load_val(width_q)),
        .dec      (state == ST_WAIT),
        .zero     (tmo_zero)
    );

    assign tmo_hit      = (state == ST_WAIT) && !(bus.pulse_valid || zw_sr[1]) && tmo_zero;
    assign bus.io_error = err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    // Burst sequencer: every output is a register updated alongside the state
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state     <= ST_IDLE;
            en_q      <= 1'b0;
            pwm_dis_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            left_q    <= '0;
            width_q   <= '0;
            gap_q     <= '0;
            zw_sr     <= '0;
`ifdef PULSE_BURST_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            en_q      <= 1'b0;
            pwm_dis_q <= 1'b0;
            done_q    <= 1'b0;
            zw_sr     <= {zw_sr[0], 1'b0};
            if (stop) begin
                state     <= ST_FINISH;
                pwm_dis_q <= 1'b1;
                left_q    <= '0;
                zw_sr     <= '0;
`ifdef PULSE_BURST_TIMEOUT_EN
                if (tmo_hit) begin
                    err_q <= 1'b1;
                end
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.io_start) begin
                            busy_q  <= 1'b1;
                            left_q  <= bus.io_pulseCount;
                            width_q <= bus.io_pulseWidth;
                            gap_q   <= bus.io_gap;
`ifdef PULSE_BURST_TIMEOUT_EN
                            err_q   <= 1'b0;
`endif
                            if ((bus.io_pulseCount != '0) && (bus.io_trigDelay == '0)) begin
                                state <= ST_FIRE;
                                en_q  <= 1'b1;
                            end else begin
                                state <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (left_q == '0) begin
                            state  <= ST_FINISH;
                            done_q <= 1'b1;
                        end else if (dly_zero) begin
                            state <= ST_FIRE;
                            en_q  <= 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        left_q <= (left_q == '0) ? '0 : left_q - CNT_WIDTH'(1);
                        zw_sr  <= {zw_sr[0], (width_q == '0)};
                        state  <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (pulse_end) begin
                            zw_sr <= '0;
                            if (left_q == '0) begin
                                state  <= ST_FINISH;
                                done_q <= 1'b1;
                            end else if (gap_q == '0) begin
                                state <= ST_FIRE;
                                en_q  <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_zero) begin
                            state <= ST_FIRE;
                            en_q  <= 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        // After a forced stop, one more cycle is spent here to place io_done behind pwm_dis
                        if (pwm_dis_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.io_en            = en_q;
    assign bus.io_pulseWidthOut = width_q;
    assign bus.pwm_dis          = pwm_dis_q;
    assign bus.io_busy          = busy_q;
    assign bus.io_done          = done_q;
    assign bus.io_pulsesLeft    = left_q;

endmodule
